systolic_array_os: RTL and testbench

Parametrised ROWS x COLS output-stationary systolic MAC array, the second-generation successor to the 1xN weight-stationary array. Takes one activation vector (ROWS lanes) and one weight vector (COLS lanes) per accepted beat over a K-length reduction, skews them internally, accumulates one output per PE, then requantises and drains results one row per beat. Sits between the activation/weight buffers and the output writeback buffer, with valid/ready on both sides.

---
 rtl/systolic_pkg.sv | 32 +++
 rtl/systolic_pe_os.sv | 45 ++++
 rtl/systolic_array_os.sv | 177 +++++++++++++++++
 tb/tb_systolic_array_os.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types, default widths and the requantisation helper for the
// output-stationary systolic MAC array.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  localparam int DEF_ROWS    = 4;
  localparam int DEF_COLS    = 4;
  localparam int DEF_BW_ACT  = 8;
  localparam int DEF_BW_WET  = 8;
  localparam int DEF_BW_ACCU = 32;
  localparam int DEF_BW_OUT  = 8;

  // acc arrives sign-extended to 64 bits, so the optional rounding add can never overflow
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input logic [4:0] sh,
                                                 input bit rnd,
                                                 input int bw_out);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v = acc;
    if (rnd && (sh != 5'd0)) v = v + (64'sd1 <<< (sh - 5'd1));
    v = v >>> sh;
    hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bw_out - 1));
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/systolic_pe_os.sv
// Output-stationary processing element: registered act/wet pass-through and a
// wrapping accumulator that can be reloaded with the current product.
module systolic_pe_os
  import systolic_pkg::*;
#(
  parameter int BW_ACT  = DEF_BW_ACT,
  parameter int BW_WET  = DEF_BW_WET,
  parameter int BW_ACCU = DEF_BW_ACCU
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clr,
  input  logic signed [BW_ACT-1:0]  i_act,
  input  logic signed [BW_WET-1:0]  i_wet,
  output logic signed [BW_ACT-1:0]  o_act,
  output logic signed [BW_WET-1:0]  o_wet,
  output logic signed [BW_ACCU-1:0] o_acc
);

  logic signed [BW_ACT+BW_WET-1:0] w_prod;
  logic signed [BW_ACCU-1:0]       w_prod_ext;
  logic signed [BW_ACT-1:0]        r_act;
  logic signed [BW_WET-1:0]        r_wet;
  logic signed [BW_ACCU-1:0]       r_acc;

  assign w_prod     = i_act * i_wet;
  assign w_prod_ext = {{(BW_ACCU-BW_ACT-BW_WET){w_prod[BW_ACT+BW_WET-1]}}, w_prod};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_act <= '0;
      r_wet <= '0;
      r_acc <= '0;
    end else begin
      r_act <= i_act;
      r_wet <= i_wet;
      r_acc <= i_clr ? w_prod_ext : r_acc + w_prod_ext;
    end
  end

  assign o_act = r_act;
  assign o_wet = r_wet;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_os.sv
// ROWS x COLS output-stationary systolic MAC array with skewed inputs,
// flush, and registered requantised row drain. Option: SYSTOLIC_ROUND_EN.
module systolic_array_os
  import systolic_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int BW_ACT  = DEF_BW_ACT,
  parameter int BW_WET  = DEF_BW_WET,
  parameter int BW_ACCU = DEF_BW_ACCU,
  parameter int BW_OUT  = DEF_BW_OUT
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ROWS-1:0][BW_ACT-1:0]               in_act,
  input  logic [COLS-1:0][BW_WET-1:0]               in_wet,
  input  logic                                      in_k_last,
  input  logic [4:0]                                shift_num,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [COLS-1:0][BW_OUT-1:0]               out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL_W  = $clog2(ROWS + COLS);
`ifdef SYSTOLIC_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  state_t r_state, w_next;
  logic   w_accept, w_clr, w_flush_done, w_last_acc;
  logic [FL_W-1:0]  r_fcnt;
  logic [4:0]       r_shift;
  logic             r_out_valid;
  logic [ROW_W-1:0] r_out_row, w_load_row;
  logic [COLS-1:0][BW_OUT-1:0] r_out_data, w_req;

  logic signed [BW_ACT-1:0]  w_act_g   [ROWS];
  logic signed [BW_WET-1:0]  w_wet_g   [COLS];
  logic signed [BW_ACT-1:0]  w_act_h   [ROWS][COLS+1];
  logic signed [BW_WET-1:0]  w_wet_v   [ROWS+1][COLS];
  logic signed [BW_ACCU-1:0] w_acc     [ROWS][COLS];
  logic [ROWS-1:0]           w_unused_act;
  logic [COLS-1:0]           w_unused_wet;

  assign w_accept     = in_valid && in_ready;
  assign w_clr        = w_accept && (r_state == IDLE);
  assign w_flush_done = (r_state == FLUSH) && (r_fcnt == FL_W'(ROWS + COLS - 2));
  assign w_last_acc   = r_out_valid && out_ready && (r_out_row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      IDLE, FEED: begin
        in_ready = 1'b1;
        if (w_accept) w_next = in_k_last ? FLUSH : FEED;
      end
      FLUSH:   if (w_flush_done) w_next = DRAIN;
      DRAIN:   if (w_last_acc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_fcnt <= (r_state == FLUSH) ? r_fcnt + 1'b1 : '0;
      if (w_accept && in_k_last) r_shift <= shift_num;
    end
  end

  // Skew stage: non-accepted cycles inject zeros; row r / column c delayed r / c cycles
  always_comb begin
    for (int r = 0; r < ROWS; r++) w_act_g[r] = w_accept ? signed'(in_act[r]) : '0;
    for (int c = 0; c < COLS; c++) w_wet_g[c] = w_accept ? signed'(in_wet[c]) : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_act_skew
    if (r == 0) begin : g_direct
      assign w_act_h[0][0] = w_act_g[0];
    end else begin : g_chain
      logic signed [BW_ACT-1:0] r_sk [r];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < r; j++) r_sk[j] <= '0;
        end else begin
          r_sk[0] <= w_act_g[r];
          for (int j = 1; j < r; j++) r_sk[j] <= r_sk[j-1];
        end
      end
      assign w_act_h[r][0] = r_sk[r-1];
    end
    assign w_unused_act[r] = ^w_act_h[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wet_skew
    if (c == 0) begin : g_direct
      assign w_wet_v[0][0] = w_wet_g[0];
    end else begin : g_chain
      logic signed [BW_WET-1:0] r_sk [c];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int j = 0; j < c; j++) r_sk[j] <= '0;
        end else begin
          r_sk[0] <= w_wet_g[c];
          for (int j = 1; j < c; j++) r_sk[j] <= r_sk[j-1];
        end
      end
      assign w_wet_v[0][c] = r_sk[c-1];
    end
    assign w_unused_wet[c] = ^w_wet_v[ROWS][c];
  end

  // PE mesh: activations travel right, weights travel down
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_pe_os #(.BW_ACT(BW_ACT), .BW_WET(BW_WET), .BW_ACCU(BW_ACCU)) u_pe (
        .i_clk (clk),
        .i_rst (reset),
        .i_clr (w_clr),
        .i_act (w_act_h[r][c]),
        .i_wet (w_wet_v[r][c]),
        .o_act (w_act_h[r][c+1]),
        .o_wet (w_wet_v[r+1][c]),
        .o_acc (w_acc[r][c])
      );
    end
  end

  // Requantisation stage: next row is computed while the current one is presented
  assign w_load_row = r_out_valid ? ROW_W'(r_out_row + 1'b1) : '0;

  always_comb begin
    w_req = '0;
    for (int c = 0; c < COLS; c++)
      w_req[c] = BW_OUT'(requant(64'(w_acc[w_load_row][c]), r_shift, ROUND_EN, BW_OUT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_data  <= '0;
    end else if (r_state == DRAIN) begin
      if (!r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_row   <= w_load_row;
        r_out_data  <= w_req;
      end else if (out_ready) begin
        if (w_last_acc) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_row  <= w_load_row;
          r_out_data <= w_req;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_systolic_array_os.sv
// Scoreboard bench for a 2x2 systolic_array_os: directed tiles push expected
// rows, a forked monitor pops and compares on every accepted output row.
module tb_systolic_array_os;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0][7:0]  in_act;
  logic [1:0][7:0]  in_wet;
  logic             in_k_last;
  logic [4:0]       shift_num;
  logic             out_valid;
  logic             out_ready;
  logic [1:0][7:0]  out_data;
  logic [0:0]       out_row;

  typedef struct packed {
    logic [0:0]  row;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_fail;

  systolic_array_os #(
    .ROWS(2), .COLS(2), .BW_ACT(8), .BW_WET(8), .BW_ACCU(32), .BW_OUT(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wet    (in_wet),
    .in_k_last (in_k_last),
    .shift_num (shift_num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
    end
  endtask

  task automatic push(input int row, input int d0, input int d1);
    sb.push_back({1'(row), 8'(d1), 8'(d0)});
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_row", 32'(out_row), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_row", 32'(out_row), 32'(e.row));
          chk("sb_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic beat(input int a0, input int a1, input int w0, input int w1,
                      input bit last, input int sh);
    chk("beat_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_act[0] = 8'(a0);
    in_act[1] = 8'(a1);
    in_wet[0] = 8'(w0);
    in_wet[1] = 8'(w1);
    in_k_last = last;
    shift_num = 5'(sh);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_k_last = 1'b0;
    in_act    = '0;
    in_wet    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drained();
    int i;
    i = 0;
    while (!(in_ready && !out_valid && sb.size() == 0) && i < 60) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_timeout", 32'(i < 60), 32'd1);
  endtask

  task automatic tile_k3(input bit gaps);
    push(0, -1, 12);
    push(1, 5, 1);
    beat( 1,  2, 3,  4, 1'b0, 0);
    if (gaps) idle(2);
    beat(-2,  1, 5, -1, 1'b0, 0);
    if (gaps) idle(2);
    beat( 3, -3, 2,  2, 1'b1, 0);
    wait_drained();
  endtask

  initial begin
    logic [15:0] hold_d;
    logic [0:0]  hold_r;
    int          i;
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_act    = '0;
    in_wet    = '0;
    in_k_last = 1'b0;
    shift_num = '0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none

    idle(2);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    reset = 1'b0;
    idle(1);

    // K=1 basic tile and first-output latency
    push(0, 3, 4);
    push(1, 6, 8);
    beat(1, 2, 3, 4, 1'b1, 0);
    chk("ready_drop", 32'(in_ready), 32'd0);
    idle(3);
    chk("latency_early", 32'(out_valid), 32'd0);
    idle(1);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("latency_row0", 32'(out_row), 32'd0);
    wait_drained();

    // Saturation both ways
    push(0, 127, 127);
    push(1, 127, 127);
    for (int k = 0; k < 4; k++) beat(127, 127, 127, 127, k == 3, 0);
    wait_drained();
    push(0, -128, -128);
    push(1, -128, -128);
    for (int k = 0; k < 4; k++) beat(-128, -128, 127, 127, k == 3, 0);
    wait_drained();

    // Shift by one on +5 / -5
`ifdef SYSTOLIC_ROUND_EN
    push(0, 3, 3);
    push(1, -2, -2);
`else
    push(0, 2, 2);
    push(1, -3, -3);
`endif
    beat(5, -5, 1, 1, 1'b1, 1);
    wait_drained();

    // Backpressure on row 0
    out_ready = 1'b0;
    push(0, -2, 5);
    push(1, 6, -15);
    beat(-1, 3, 2, -5, 1'b1, 0);
    i = 0;
    while (!out_valid && i < 20) begin idle(1); i++; end
    chk("bp_valid_timeout", 32'(i < 20), 32'd1);
    hold_d = out_data;
    hold_r = out_row;
    chk("bp_row0", 32'(hold_r), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("bp_hold_data", 32'(out_data), 32'(hold_d));
      chk("bp_hold_row", 32'(out_row), 32'(hold_r));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    wait_drained();

    // Gapless then gapped K=3, back to back
    tile_k3(1'b0);
    tile_k3(1'b1);

    // Reset in the middle of FLUSH
    beat(7, 7, 7, 7, 1'b1, 0);
    idle(1);
    reset = 1'b1;
    idle(1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    push(0, 3, 4);
    push(1, 6, 8);
    beat(1, 2, 3, 4, 1'b1, 0);
    wait_drained();

    idle(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
